ifmap_serializer: RTL
=====================

Name: ifmap_serializer

Overview:
Parametrised wide-to-narrow ifmap serializer for the accelerator input path. It accepts IN_W-bit ifmap words over a valid/ready handshake and emits ELEM_W-bit elements, lowest element first, over a valid/ready handshake. A two-entry buffer (active shift register plus one pending word) keeps the output stream gap-free across words. Per-word element count supports partial tail words, and an end-of-tile flag is propagated to the final element.

Parameters:
IN_W, 32, input word width; must be an integer multiple of ELEM_W
ELEM_W, 8, output element width
NELEM, IN_W/ELEM_W, derived localparam, elements per word (not overridable)
CNT_W, $clog2(NELEM+1), derived localparam, width of element counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  input word valid
in_ready  output  1  serializer can accept a word this cycle
in_data  input  IN_W  ifmap word; element k = in_data[k*ELEM_W +: ELEM_W]
in_cnt  input  CNT_W  number of valid elements in word; 0 means NELEM; values >NELEM clamp to NELEM
in_last  input  1  word is last of tile
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts element
out_data  output  ELEM_W  current element
out_last  output  1  final element of a word tagged in_last
busy  output  1  active or pending word held

Behaviour:
- One clock; reset is synchronous and active-high: rst sampled on rising clk edge clears all state.
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1 the cycle after reset; active and pending invalid, counters 0.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_data/out_last/out_valid are registered and held stable while out_valid & !out_ready.
- in_ready = !pending_valid (combinational from registered state only; no dependency on out_ready).
- States: EMPTY (no active word), STREAM (active only), FULL (active + pending).
- active_done = out_fire & (remaining == 1).
- EMPTY: in_fire -> load active, remaining = eff_cnt, go STREAM. Latency: first element out_valid the cycle after in_fire.
- STREAM: out_fire with remaining>1 -> shift active right by ELEM_W, remaining--. in_fire with !active_done -> write pending, go FULL. in_fire with active_done -> load input directly into active, stay STREAM. active_done without in_fire -> EMPTY.
- FULL: in_ready=0. active_done -> move pending into active, go STREAM, no bubble. Otherwise shift as STREAM.
- out_last = active_last & (remaining == 1).
- Throughput: with out_ready held 1 and input supplied each needed cycle, one element per cycle continuously across word boundaries.
- Partial word: only eff_cnt elements emitted; upper elements discarded.
- Reset mid-word: all held data discarded; no further out_valid until a new word is accepted.
- busy = state != EMPTY.

Optional Feature:
Macro IFMAP_SER_MSB_FIRST_EN. Defined: elements are emitted highest index first (element NELEM-1 down to 0). Active shifts left by ELEM_W and out_data = top ELEM_W bits. Partial words drop the low elements, so with in_cnt=c the emitted elements are NELEM-1 down to NELEM-c. Undefined: LSB-first order as above. Handshake, timing, and out_last are identical in both builds.

Test Plan:
- Defaults, in_data=0x44332211, in_cnt=0, in_last=0, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after in_fire; out_last=0 throughout.
- Back-to-back words 0x44332211 then 0x88776655 (in_last=1), in_valid held, out_ready=1 -> 8 consecutive elements 0x11..0x88, no gap; out_last=1 only with 0x88; in_ready=0 while FULL.
- Backpressure: out_ready toggles 1,0,0,1,... on 0xDDCCBBAA -> each element held stable while stalled; order AA,BB,CC,DD; no loss or duplication.
- Partial and clamp: 0x44332211 in_cnt=3 in_last=1 -> 0x11,0x22,0x33 with out_last on 0x33. Then in_cnt=7 -> 4 elements.
- Reset mid-word: after emitting 0x11, assert rst 1 cycle -> next cycle out_valid=0, busy=0, in_ready=1. A subsequent word 0x0000AB00 emits 0x00,0xAB,0x00,0x00.
- IFMAP_SER_MSB_FIRST_EN build: 0x44332211 in_cnt=2 -> 0x44,0x33 with in_last propagated to 0x33.

Source files
------------

// File: rtl/ifmap_serializer.sv
// ---------------------------------------------------------------------------
// ifmap_serializer
//
// Wide-to-narrow serializer for the accelerator ifmap input path. Accepts
// IN_W-bit words on a valid/ready handshake and emits ELEM_W-bit elements on
// a valid/ready handshake. An active shift register plus one pending word
// keep the output stream gap-free across word boundaries. Each word carries
// an element count (partial tail words) and an end-of-tile flag that is
// attached to the final emitted element of that word.
//
// Optional build macro: IFMAP_SER_MSB_FIRST_EN
//   undefined : elements emitted lowest index first (default)
//   defined   : elements emitted highest index first; partial words drop
//               the low elements
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input word valid
//   in_ready   serializer can accept a word this cycle
//   in_data    ifmap word, element k = in_data[k*ELEM_W +: ELEM_W]
//   in_cnt     valid elements in word; 0 or >NELEM means NELEM
//   in_last    word is last of tile
//   out_valid  out_data valid
//   out_ready  downstream accepts element
//   out_data   current element
//   out_last   final element of a word tagged in_last
//   busy       active or pending word held
//
// state   | meaning
// --------+----------------------------------------------
// EMPTY   | no word held, output idle
// STREAM  | active word being emitted, pending slot free
// FULL    | active word being emitted, pending slot holds next word
// ---------------------------------------------------------------------------
module ifmap_serializer #(
    parameter  int IN_W   = 32,
    parameter  int ELEM_W = 8,
    localparam int NELEM  = IN_W / ELEM_W,
    localparam int CNT_W  = $clog2(NELEM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_STREAM = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NELEM);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q,     state_d;
    logic [IN_W-1:0]   act_data_q,  act_data_d;
    logic              act_last_q,  act_last_d;
    logic [CNT_W-1:0]  rem_q,       rem_d;
    logic [IN_W-1:0]   pend_data_q, pend_data_d;
    logic [CNT_W-1:0]  pend_cnt_q,  pend_cnt_d;
    logic              pend_last_q, pend_last_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;

    logic              in_fire;
    logic              out_fire;
    logic              active_done;
    logic [CNT_W-1:0]  eff_cnt;
    logic [IN_W-1:0]   act_shifted;

    // in_ready depends only on registered state so upstream never sees a
    // combinational path from out_ready.
    assign in_ready    = (state_q != S_FULL);
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid_q & out_ready;
    assign active_done = out_fire & (rem_q == CNT_ONE);

    assign eff_cnt = ((in_cnt == '0) || (in_cnt > CNT_FULL)) ? CNT_FULL : in_cnt;

`ifdef IFMAP_SER_MSB_FIRST_EN
    assign act_shifted = act_data_q << ELEM_W;
    assign out_data    = act_data_q[IN_W-1 -: ELEM_W];
`else
    assign act_shifted = act_data_q >> ELEM_W;
    assign out_data    = act_data_q[ELEM_W-1:0];
`endif

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_EMPTY);

    always_comb begin
        state_d     = state_q;
        act_data_d  = act_data_q;
        act_last_d  = act_last_q;
        rem_d       = rem_q;
        pend_data_d = pend_data_q;
        pend_cnt_d  = pend_cnt_q;
        pend_last_d = pend_last_q;

        // Advance within the active word; the final element is not shifted
        // because the active register is about to be reloaded or released.
        if (out_fire && (rem_q > CNT_ONE)) begin
            act_data_d = act_shifted;
            rem_d      = rem_q - CNT_ONE;
        end

        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    act_data_d = in_data;
                    act_last_d = in_last;
                    rem_d      = eff_cnt;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_fire && active_done) begin
                    // Word boundary with a new word arriving: bypass the
                    // pending slot so the stream has no bubble.
                    act_data_d = in_data;
                    act_last_d = in_last;
                    rem_d      = eff_cnt;
                end else if (in_fire) begin
                    pend_data_d = in_data;
                    pend_cnt_d  = eff_cnt;
                    pend_last_d = in_last;
                    state_d     = S_FULL;
                end else if (active_done) begin
                    rem_d      = '0;
                    act_last_d = 1'b0;
                    state_d    = S_EMPTY;
                end
            end
            S_FULL: begin
                if (active_done) begin
                    act_data_d = pend_data_q;
                    act_last_d = pend_last_q;
                    rem_d      = pend_cnt_q;
                    state_d    = S_STREAM;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        out_valid_d = (state_d != S_EMPTY);
        out_last_d  = (state_d != S_EMPTY) & act_last_d & (rem_d == CNT_ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            act_data_q  <= '0;
            act_last_q  <= 1'b0;
            rem_q       <= '0;
            pend_data_q <= '0;
            pend_cnt_q  <= '0;
            pend_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_data_q  <= act_data_d;
            act_last_q  <= act_last_d;
            rem_q       <= rem_d;
            pend_data_q <= pend_data_d;
            pend_cnt_q  <= pend_cnt_d;
            pend_last_q <= pend_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
